uart_xcvr_param: RTL and testbench

Parametrised full-duplex UART transceiver. Successor to the fixed 8-bit tx/rx pair carried on the uart interface. Adds configurable data width and stop-bit count, an internal loopback path, framing-error detection and glitch-rejecting start detection. Sits between the byte-level bus logic and the serial pins; the uart interface tx/rx signals map 1:1 onto its ports.

---
 rtl/uart_pkg.sv | 41 ++++
 rtl/uart_xcvr_param_if.sv | 33 +++
 rtl/uart_rx_core.sv | 147 ++++++++++++++
 rtl/uart_xcvr_param.sv | 151 +++++++++++++++
 tb/tb_uart_xcvr_param.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared FSM state types, parity and frame-length helpers for uart_xcvr_param.
// Optional parity support is selected with the UART_PARITY_EN macro.
package uart_pkg;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
`ifdef UART_PARITY_EN
        TX_PARITY,
`endif
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
`ifdef UART_PARITY_EN
        RX_PARITY,
`endif
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

`ifdef UART_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    function automatic int frame_clks(input int cpb, input int dbits, input int sbits);
        return (1 + dbits + PARITY_BITS + sbits) * cpb;
    endfunction

    // Payload is zero-extended to 9 bits by the caller; the extra zeros do not change the XOR.
    function automatic logic parity_bit(input logic [8:0] data, input logic odd);
        return odd ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/uart_xcvr_param_if.sv
// rtl/uart_xcvr_param_if.sv - byte-side handshake bundle of uart_xcvr_param (UART_PARITY_EN adds parity error).
interface uart_xcvr_param_if #(
    parameter int DATA_BITS = 8
) ();
    logic                 i_Tx_DV;
    logic [DATA_BITS-1:0] i_Tx_Byte;
    logic                 o_Tx_Active;
    logic                 o_Tx_Done;
    logic                 o_Rx_DV;
    logic [DATA_BITS-1:0] o_Rx_Byte;
    logic                 o_Rx_Frame_Err;
`ifdef UART_PARITY_EN
    logic                 o_Rx_Parity_Err;

    modport master (
        output i_Tx_DV, i_Tx_Byte,
        input  o_Tx_Active, o_Tx_Done, o_Rx_DV, o_Rx_Byte, o_Rx_Frame_Err, o_Rx_Parity_Err
    );
    modport slave (
        input  i_Tx_DV, i_Tx_Byte,
        output o_Tx_Active, o_Tx_Done, o_Rx_DV, o_Rx_Byte, o_Rx_Frame_Err, o_Rx_Parity_Err
    );
`else
    modport master (
        output i_Tx_DV, i_Tx_Byte,
        input  o_Tx_Active, o_Tx_Done, o_Rx_DV, o_Rx_Byte, o_Rx_Frame_Err
    );
    modport slave (
        input  i_Tx_DV, i_Tx_Byte,
        output o_Tx_Active, o_Tx_Done, o_Rx_DV, o_Rx_Byte, o_Rx_Frame_Err
    );
`endif
endinterface

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - UART receiver: 2-flop synchroniser, glitch-rejecting start, mid-bit sampling FSM.
// UART_PARITY_EN adds the parity sample state and o_Parity_Err.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87,
    parameter int DATA_BITS    = 8
`ifdef UART_PARITY_EN
    ,
    parameter int PARITY_ODD   = 0
`endif
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic                 i_Serial,
    output logic                 o_DV,
    output logic [DATA_BITS-1:0] o_Byte,
    output logic                 o_Frame_Err
`ifdef UART_PARITY_EN
    ,
    output logic                 o_Parity_Err
`endif
);
    localparam int CW = $clog2(CLKS_PER_BIT * 2);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] C_HALF      = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] C_BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] C_DATA_LAST = BW'(DATA_BITS - 1);

    rx_state_t            r_state;
    logic                 r_sync1;
    logic                 r_sync2;
    logic [CW-1:0]        r_cnt;
    logic [BW-1:0]        r_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_dv;
    logic [DATA_BITS-1:0] r_byte;
    logic                 r_ferr;
    logic                 w_rx;
`ifdef UART_PARITY_EN
    logic                 r_par_bit;
    logic                 r_perr;
`endif

    assign w_rx = r_sync2;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_state   <= RX_IDLE;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_shift   <= '0;
            r_dv      <= 1'b0;
            r_byte    <= '0;
            r_ferr    <= 1'b0;
`ifdef UART_PARITY_EN
            r_par_bit <= 1'b0;
            r_perr    <= 1'b0;
`endif
        end else begin
            r_sync1 <= i_Serial;
            r_sync2 <= r_sync1;
            r_dv    <= 1'b0;
            r_ferr  <= 1'b0;
`ifdef UART_PARITY_EN
            r_perr  <= 1'b0;
`endif
            case (r_state)
                RX_IDLE: begin
                    if (!w_rx) begin
                        r_state <= RX_START;
                        r_cnt   <= '0;
                    end
                end
                // A start that is high again at mid-bit was a glitch.
                RX_START: begin
                    if (r_cnt == C_HALF) begin
                        r_cnt   <= '0;
                        r_idx   <= '0;
                        r_state <= w_rx ? RX_IDLE : RX_DATA;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                RX_DATA: begin
                    if (r_cnt == C_BIT_LAST) begin
                        r_cnt   <= '0;
                        r_shift <= {w_rx, r_shift[DATA_BITS-1:1]};
                        if (r_idx == C_DATA_LAST) begin
`ifdef UART_PARITY_EN
                            r_state <= RX_PARITY;
`else
                            r_state <= RX_STOP;
`endif
                        end else begin
                            r_idx <= r_idx + BW'(1);
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
`ifdef UART_PARITY_EN
                RX_PARITY: begin
                    if (r_cnt == C_BIT_LAST) begin
                        r_cnt     <= '0;
                        r_par_bit <= w_rx;
                        r_state   <= RX_STOP;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
`endif
                RX_STOP: begin
                    if (r_cnt == C_BIT_LAST) begin
                        r_cnt   <= '0;
                        r_dv    <= 1'b1;
                        r_byte  <= r_shift;
                        r_ferr  <= ~w_rx;
`ifdef UART_PARITY_EN
                        r_perr  <= r_par_bit ^ parity_bit(9'(r_shift), (PARITY_ODD != 0));
`endif
                        // A low stop bit parks in WAIT_HIGH so a held break yields one frame.
                        r_state <= w_rx ? RX_IDLE : RX_WAIT_HIGH;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                RX_WAIT_HIGH: begin
                    if (w_rx) begin
                        r_state <= RX_IDLE;
                    end
                end
                default: r_state <= RX_IDLE;
            endcase
        end
    end

    assign o_DV        = r_dv;
    assign o_Byte      = r_byte;
    assign o_Frame_Err = r_ferr;
`ifdef UART_PARITY_EN
    assign o_Parity_Err = r_perr;
`endif

endmodule

// File: rtl/uart_xcvr_param.sv
// rtl/uart_xcvr_param.sv - parametrised full-duplex UART: TX FSM, loopback mux, receiver instance.
// UART_PARITY_EN inserts and checks a parity bit after the data bits.
module uart_xcvr_param
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic              i_Clock,
    input  logic              i_Reset,
    input  logic              i_Rx_Serial,
    input  logic              i_Loopback,
    output logic              o_Tx_Serial,
    uart_xcvr_param_if.slave  bus
);
    localparam int CW = $clog2(CLKS_PER_BIT * 2);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] C_BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] C_STOP_LAST = CW'(STOP_BITS * CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] C_DATA_LAST = BW'(DATA_BITS - 1);

    if (CLKS_PER_BIT < 4 || DATA_BITS < 5 || DATA_BITS > 9 ||
        (STOP_BITS != 1 && STOP_BITS != 2) || (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_bad_params
        $error("uart_xcvr_param: illegal parameter combination");
    end

    tx_state_t            r_tx_state;
    logic [CW-1:0]        r_tx_cnt;
    logic [BW-1:0]        r_tx_idx;
    logic [DATA_BITS-1:0] r_tx_shift;
    logic                 r_tx_serial;
    logic                 r_tx_active;
    logic                 r_tx_done;
    logic                 w_rx_src;
`ifdef UART_PARITY_EN
    logic                 r_tx_par;
`endif

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_tx_state  <= TX_IDLE;
            r_tx_cnt    <= '0;
            r_tx_idx    <= '0;
            r_tx_shift  <= '0;
            r_tx_serial <= 1'b1;
            r_tx_active <= 1'b0;
            r_tx_done   <= 1'b0;
`ifdef UART_PARITY_EN
            r_tx_par    <= 1'b0;
`endif
        end else begin
            r_tx_done <= 1'b0;
            case (r_tx_state)
                TX_IDLE: begin
                    if (bus.i_Tx_DV) begin
                        r_tx_state  <= TX_START;
                        r_tx_shift  <= bus.i_Tx_Byte;
                        r_tx_cnt    <= '0;
                        r_tx_idx    <= '0;
                        r_tx_serial <= 1'b0;
                        r_tx_active <= 1'b1;
`ifdef UART_PARITY_EN
                        r_tx_par    <= parity_bit(9'(bus.i_Tx_Byte), (PARITY_ODD != 0));
`endif
                    end
                end
                TX_START: begin
                    if (r_tx_cnt == C_BIT_LAST) begin
                        r_tx_cnt    <= '0;
                        r_tx_state  <= TX_DATA;
                        r_tx_serial <= r_tx_shift[0];
                    end else begin
                        r_tx_cnt <= r_tx_cnt + CW'(1);
                    end
                end
                // The shift register always presents the bit after the one on the wire at [1].
                TX_DATA: begin
                    if (r_tx_cnt == C_BIT_LAST) begin
                        r_tx_cnt <= '0;
                        if (r_tx_idx == C_DATA_LAST) begin
`ifdef UART_PARITY_EN
                            r_tx_state  <= TX_PARITY;
                            r_tx_serial <= r_tx_par;
`else
                            r_tx_state  <= TX_STOP;
                            r_tx_serial <= 1'b1;
`endif
                        end else begin
                            r_tx_idx    <= r_tx_idx + BW'(1);
                            r_tx_shift  <= r_tx_shift >> 1;
                            r_tx_serial <= r_tx_shift[1];
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + CW'(1);
                    end
                end
`ifdef UART_PARITY_EN
                TX_PARITY: begin
                    if (r_tx_cnt == C_BIT_LAST) begin
                        r_tx_cnt    <= '0;
                        r_tx_state  <= TX_STOP;
                        r_tx_serial <= 1'b1;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + CW'(1);
                    end
                end
`endif
                TX_STOP: begin
                    if (r_tx_cnt == C_STOP_LAST) begin
                        r_tx_cnt    <= '0;
                        r_tx_state  <= TX_IDLE;
                        r_tx_active <= 1'b0;
                        r_tx_done   <= 1'b1;
                        r_tx_serial <= 1'b1;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + CW'(1);
                    end
                end
                default: r_tx_state <= TX_IDLE;
            endcase
        end
    end

    assign o_Tx_Serial     = r_tx_serial;
    assign bus.o_Tx_Active = r_tx_active;
    assign bus.o_Tx_Done   = r_tx_done;
    assign w_rx_src        = i_Loopback ? r_tx_serial : i_Rx_Serial;

    uart_rx_core #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .DATA_BITS    (DATA_BITS)
`ifdef UART_PARITY_EN
        ,
        .PARITY_ODD   (PARITY_ODD)
`endif
    ) u_rx_core (
        .i_Clock      (i_Clock),
        .i_Reset      (i_Reset),
        .i_Serial     (w_rx_src),
        .o_DV         (bus.o_Rx_DV),
        .o_Byte       (bus.o_Rx_Byte),
        .o_Frame_Err  (bus.o_Rx_Frame_Err)
`ifdef UART_PARITY_EN
        ,
        .o_Parity_Err (bus.o_Rx_Parity_Err)
`endif
    );

endmodule

// File: tb/tb_uart_xcvr_param.sv
// tb/tb_uart_xcvr_param.sv - randomized self-checking bench for uart_xcvr_param against a frame-level model.
// Parity scenarios are built when UART_PARITY_EN is defined.
module tb_uart_xcvr_param;
    localparam int CPB  = 4;
    localparam int DB   = 8;
    localparam int SB   = 1;
    localparam int PODD = 0;
`ifdef UART_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int NBITS = 1 + DB + PB + SB;
    localparam int F     = NBITS * CPB;

    logic clk       = 1'b0;
    logic rst       = 1'b1;
    logic rx_serial = 1'b1;
    logic loopback  = 1'b0;
    logic tx_serial;
    logic w_perr;

    uart_xcvr_param_if #(.DATA_BITS(DB)) bus ();

    uart_xcvr_param #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (DB),
        .STOP_BITS    (SB),
        .PARITY_ODD   (PODD)
    ) dut (
        .i_Clock     (clk),
        .i_Reset     (rst),
        .i_Rx_Serial (rx_serial),
        .i_Loopback  (loopback),
        .o_Tx_Serial (tx_serial),
        .bus         (bus)
    );

`ifdef UART_PARITY_EN
    assign w_perr = bus.o_Rx_Parity_Err;
`else
    assign w_perr = 1'b0;
`endif

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference model: the frame as a list of bit values on the wire.
    function automatic logic exp_parity(input logic [DB-1:0] d);
        int ones = 0;
        for (int i = 0; i < DB; i++) ones += int'(d[i]);
        return ((ones + PODD) % 2) == 1;
    endfunction

    function automatic logic frame_bit(input logic [DB-1:0] d, input int j);
        if (j == 0) return 1'b0;
        if (j <= DB) return d[j-1];
        if (PB == 1 && j == DB + 1) return exp_parity(d);
        return 1'b1;
    endfunction

    logic [DB+1:0] rx_q[$];
    int done_cnt = 0;

    always @(negedge clk) begin
        if (bus.o_Rx_DV) rx_q.push_back({w_perr, bus.o_Rx_Frame_Err, bus.o_Rx_Byte});
        if (bus.o_Tx_Done) done_cnt++;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pop_rx(input string tag, input logic [DB-1:0] d, input logic ferr, input logic perr);
        logic [DB+1:0] e;
        if (rx_q.size() == 0) begin
            check({tag, "_present"}, 0, 1);
        end else begin
            e = rx_q.pop_front();
            check({tag, "_byte"}, e[DB-1:0], d);
            check({tag, "_ferr"}, e[DB], ferr);
            check({tag, "_perr"}, e[DB+1], perr);
        end
    endtask

    // Called at a negedge; checks every cycle of the frame plus the done cycle.
    task automatic tx_frame(input logic [DB-1:0] d, input bit poke);
        int bad = 0;
        bus.i_Tx_DV   = 1'b1;
        bus.i_Tx_Byte = d;
        for (int k = 1; k <= F + 1; k++) begin
            @(negedge clk);
            if (k == 1) bus.i_Tx_DV = 1'b0;
            if (poke && k == 15) begin
                bus.i_Tx_DV   = 1'b1;
                bus.i_Tx_Byte = ~d;
            end
            if (poke && k == 16) bus.i_Tx_DV = 1'b0;
            if (k <= F) begin
                if (tx_serial !== frame_bit(d, (k - 1) / CPB) || bus.o_Tx_Active !== 1'b1 ||
                    bus.o_Tx_Done !== 1'b0) bad++;
            end else begin
                check("tx_done_pulse", bus.o_Tx_Done, 1);
                check("tx_active_end", bus.o_Tx_Active, 0);
            end
        end
        check("tx_wave_bad_cycles", bad, 0);
    endtask

    task automatic rx_drive(input logic [DB-1:0] d, input logic stop_val, input logic flip_par);
        for (int j = 0; j < NBITS; j++) begin
            logic b;
            b = frame_bit(d, j);
            if (j == 1 + DB + PB) b = stop_val;
            if (PB == 1 && j == DB + 1) b = b ^ flip_par;
            rx_serial = b;
            wait_cycles(CPB);
        end
        rx_serial = 1'b1;
    endtask

    initial begin
        logic [DB-1:0] d;
        logic [DB-1:0] d2;
        int act;
        bus.i_Tx_DV   = 1'b0;
        bus.i_Tx_Byte = '0;
        wait_cycles(3);
        check("rst_tx_serial", tx_serial, 1);
        check("rst_tx_active", bus.o_Tx_Active, 0);
        check("rst_tx_done", bus.o_Tx_Done, 0);
        check("rst_rx_dv", bus.o_Rx_DV, 0);
        check("rst_rx_byte", bus.o_Rx_Byte, 0);
        rst = 1'b0;
        loopback = 1'b1;
        wait_cycles(4);

        for (int i = 0; i < 6; i++) begin
            d = (i == 0) ? DB'(8'hA5) : DB'($urandom);
            rx_q.delete();
            tx_frame(d, 1'b0);
            wait_cycles(3 * CPB);
            check("lb_count", rx_q.size(), 1);
            pop_rx("lb", d, 1'b0, 1'b0);
            wait_cycles($urandom_range(0, 3));
        end

        d  = DB'($urandom);
        d2 = DB'($urandom);
        rx_q.delete();
        tx_frame(d, 1'b0);
        tx_frame(d2, 1'b0);
        wait_cycles(3 * CPB);
        check("b2b_count", rx_q.size(), 2);
        pop_rx("b2b_first", d, 1'b0, 1'b0);
        pop_rx("b2b_second", d2, 1'b0, 1'b0);

        rx_q.delete();
        tx_frame(DB'(8'h01), 1'b1);
        act = 0;
        repeat (F) begin
            @(negedge clk);
            act += int'(bus.o_Tx_Active);
        end
        check("busy_dv_ignored", act, 0);
        check("busy_rx_count", rx_q.size(), 1);
        pop_rx("busy", DB'(8'h01), 1'b0, 1'b0);

        loopback = 1'b0;
        wait_cycles(4);
        rx_q.delete();
        rx_serial = 1'b0;
        wait_cycles(1);
        rx_serial = 1'b1;
        wait_cycles(4 * CPB);
        check("glitch_no_dv", rx_q.size(), 0);
        rx_drive(DB'(8'h3C), 1'b1, 1'b0);
        wait_cycles(3 * CPB);
        check("post_glitch_count", rx_q.size(), 1);
        pop_rx("post_glitch", DB'(8'h3C), 1'b0, 1'b0);

        for (int i = 0; i < 4; i++) begin
            d = DB'($urandom);
            rx_drive(d, 1'b1, 1'b0);
            wait_cycles(3 * CPB + $urandom_range(0, 5));
            check("rx_rand_count", rx_q.size(), 1);
            pop_rx("rx_rand", d, 1'b0, 1'b0);
        end

        rx_drive(DB'(8'h55), 1'b0, 1'b0);
        rx_serial = 1'b0;
        wait_cycles(20);
        check("break_count", rx_q.size(), 1);
        pop_rx("break", DB'(8'h55), 1'b1, 1'b0);
        rx_serial = 1'b1;
        wait_cycles(3 * CPB);
        check("break_no_extra", rx_q.size(), 0);
        d = DB'($urandom);
        rx_drive(d, 1'b1, 1'b0);
        wait_cycles(3 * CPB);
        check("after_break_count", rx_q.size(), 1);
        pop_rx("after_break", d, 1'b0, 1'b0);

`ifdef UART_PARITY_EN
        rx_drive(DB'(8'h07), 1'b1, 1'b1);
        wait_cycles(3 * CPB);
        check("par_err_count", rx_q.size(), 1);
        pop_rx("par_err", DB'(8'h07), 1'b0, 1'b1);
`endif

        loopback = 1'b1;
        wait_cycles(4);
        rx_q.delete();
        done_cnt = 0;
        bus.i_Tx_DV   = 1'b1;
        bus.i_Tx_Byte = DB'($urandom);
        @(negedge clk);
        bus.i_Tx_DV = 1'b0;
        wait_cycles(14);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_tx_serial", tx_serial, 1);
        check("midrst_tx_active", bus.o_Tx_Active, 0);
        check("midrst_tx_done", bus.o_Tx_Done, 0);
        rst = 1'b0;
        wait_cycles(F + 10);
        check("midrst_no_done", done_cnt, 0);
        check("midrst_no_rx", rx_q.size(), 0);
        tx_frame(DB'(8'hFF), 1'b0);
        wait_cycles(3 * CPB);
        check("post_rst_count", rx_q.size(), 1);
        pop_rx("post_rst", DB'(8'hFF), 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
